// File: rtl/gate_check_pkg.sv
`default_nettype none
// =============================================================================
// Module   : gate_check_pkg
// Brief    : Shared FSM state type and standard 2-input truth tables.
// Revision : 1.0 - initial release
// =============================================================================
package gate_check_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_APPLY  = 2'd1,
    ST_SAMPLE = 2'd2,
    ST_DONE   = 2'd3
  } state_t;

  // Truth tables are indexed by {a,b}: bit 0 is a=0,b=0.
  localparam logic [3:0] TT_AND  = 4'b1000;
  localparam logic [3:0] TT_OR   = 4'b1110;
  localparam logic [3:0] TT_XOR  = 4'b0110;
  localparam logic [3:0] TT_NAND = 4'b0111;
  localparam logic [3:0] TT_NOR  = 4'b0001;

  function automatic logic expected_bit(input logic [3:0] tt, input logic [1:0] vec);
    return tt[vec];
  endfunction

endpackage
`default_nettype wire

// File: rtl/settle_timer.sv
`default_nettype none
// =============================================================================
// Module   : settle_timer
// Brief    : 4-bit settle counter; expired while count equals SETTLE-1.
// Revision : 1.0 - initial release
// =============================================================================
module settle_timer #(
  parameter int SETTLE = 2
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clear,
  input  logic enable,
  output logic expired
);

  localparam logic [3:0] c_last = 4'(SETTLE - 1);

  logic [3:0] r_count;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_count <= 4'd0;
    end else if (clear) begin
      r_count <= 4'd0;
    end else if (enable) begin
      r_count <= r_count + 4'd1;
    end
  end

  assign expired = (r_count == c_last);

endmodule
`default_nettype wire

// File: rtl/gate_truth_checker.sv
`default_nettype none
// =============================================================================
// Module   : gate_truth_checker
// Brief    : Clocked self-test sweep of a 2-input gate against a truth table.
// Revision : 1.0 - initial release
// =============================================================================
module gate_truth_checker
  import gate_check_pkg::*;
#(
  parameter logic [3:0] EXPECT = TT_OR,
  parameter int         SETTLE = 2
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start,
  output logic       a,
  output logic       b,
  input  logic       y,
  output logic       busy,
  output logic       done,
  output logic       pass,
  output logic [2:0] err_count,
  output logic [3:0] fail_vec
);

  state_t     r_state;
  state_t     w_state_next;
  logic [1:0] r_idx;
  logic [1:0] r_ab;
  logic       r_busy;
  logic       r_done;
  logic       r_pass;
  logic [2:0] r_err_count;
  logic [3:0] r_fail_vec;

  logic       w_sweep_start;
  logic       w_sample;
  logic       w_last;
  logic       w_expired;
  logic       w_mismatch;
  logic [2:0] w_err_next;

  settle_timer #(
    .SETTLE (SETTLE)
  ) u_settle_timer (
    .clk     (clk),
    .rst_n   (rst_n),
    .clear   (r_state != ST_APPLY),
    .enable  (r_state == ST_APPLY),
    .expired (w_expired)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  always_comb begin
    w_state_next  = r_state;
    w_sweep_start = 1'b0;
    w_sample      = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (start) begin
          w_sweep_start = 1'b1;
          w_state_next  = ST_APPLY;
        end
      end
      ST_APPLY: begin
        if (w_expired) begin
          w_state_next = ST_SAMPLE;
        end
      end
      ST_SAMPLE: begin
        w_sample     = 1'b1;
        w_state_next = w_last ? ST_DONE : ST_APPLY;
      end
      ST_DONE: begin
        w_state_next = ST_IDLE;
      end
      default: begin
        w_state_next = ST_IDLE;
      end
    endcase
  end

  assign w_last     = (r_idx == 2'd3);
  assign w_mismatch = (y != expected_bit(EXPECT, r_idx));
  assign w_err_next = r_err_count + 3'(w_mismatch);

  // Status flags are registered from the next state so they line up with it.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_idx       <= 2'd0;
      r_ab        <= 2'd0;
      r_busy      <= 1'b0;
      r_done      <= 1'b0;
      r_pass      <= 1'b0;
      r_err_count <= 3'd0;
      r_fail_vec  <= 4'd0;
    end else begin
      r_busy <= (w_state_next != ST_IDLE);
      r_done <= (w_state_next == ST_DONE);
      if (w_sweep_start) begin
        r_idx       <= 2'd0;
        r_ab        <= 2'd0;
        r_pass      <= 1'b0;
        r_err_count <= 3'd0;
        r_fail_vec  <= 4'd0;
      end else if (w_sample) begin
        if (w_mismatch) begin
          r_err_count       <= w_err_next;
          r_fail_vec[r_idx] <= 1'b1;
        end
        if (w_last) begin
          r_pass <= (w_err_next == 3'd0);
          r_ab   <= 2'd0;
        end else begin
          r_idx <= r_idx + 2'd1;
          r_ab  <= r_idx + 2'd1;
        end
      end
    end
  end

  assign a         = r_ab[1];
  assign b         = r_ab[0];
  assign busy      = r_busy;
  assign done      = r_done;
  assign pass      = r_pass;
  assign err_count = r_err_count;
  assign fail_vec  = r_fail_vec;

endmodule
`default_nettype wire

// File: tb/tb_gate_truth_checker.sv
`default_nettype none
// =============================================================================
// Module   : tb_gate_truth_checker
// Brief    : Directed self-checking bench for gate_truth_checker.
// Revision : 1.0 - initial release
// =============================================================================
module tb_gate_truth_checker;
  import gate_check_pkg::*;

  logic clk = 1'b0;
  logic rst_n;
  logic start;
  logic [1:0] mode;   // 0: OR gate, 1: AND gate, 2: tied 0, 3: tied 1

  int checks = 0;
  int errors = 0;

  logic       or2_a, or2_b, or2_y, or2_busy, or2_done, or2_pass;
  logic [2:0] or2_err;
  logic [3:0] or2_fv;
  logic       or1_a, or1_b, or1_y, or1_busy, or1_done, or1_pass;
  logic [2:0] or1_err;
  logic [3:0] or1_fv;
  logic       nor_a, nor_b, nor_busy, nor_done, nor_pass;
  logic [2:0] nor_err;
  logic [3:0] nor_fv;

  always #5 clk = ~clk;

  always_comb begin
    case (mode)
      2'd0:    or2_y = or2_a | or2_b;
      2'd1:    or2_y = or2_a & or2_b;
      2'd2:    or2_y = 1'b0;
      default: or2_y = 1'b1;
    endcase
  end
  assign or1_y = or1_a | or1_b;

  gate_truth_checker #(.EXPECT(TT_OR), .SETTLE(2)) u_or2 (
    .clk(clk), .rst_n(rst_n), .start(start), .a(or2_a), .b(or2_b), .y(or2_y),
    .busy(or2_busy), .done(or2_done), .pass(or2_pass), .err_count(or2_err), .fail_vec(or2_fv));

  gate_truth_checker #(.EXPECT(TT_OR), .SETTLE(1)) u_or1 (
    .clk(clk), .rst_n(rst_n), .start(start), .a(or1_a), .b(or1_b), .y(or1_y),
    .busy(or1_busy), .done(or1_done), .pass(or1_pass), .err_count(or1_err), .fail_vec(or1_fv));

  gate_truth_checker #(.EXPECT(TT_NOR), .SETTLE(2)) u_nor (
    .clk(clk), .rst_n(rst_n), .start(start), .a(nor_a), .b(nor_b), .y(1'b1),
    .busy(nor_busy), .done(nor_done), .pass(nor_pass), .err_count(nor_err), .fail_vec(nor_fv));

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_or2_idle_zero(input string tag);
    check({tag, "_busy"}, 8'(or2_busy), 8'h0);
    check({tag, "_done"}, 8'(or2_done), 8'h0);
    check({tag, "_pass"}, 8'(or2_pass), 8'h0);
    check({tag, "_err"},  8'(or2_err),  8'h0);
    check({tag, "_fv"},   8'(or2_fv),   8'h0);
    check({tag, "_ab"},   8'({or2_a, or2_b}), 8'h0);
  endtask

  // One SETTLE=2 sweep; cycle c is the c-th cycle after the edge that samples start.
  task automatic sweep_or2(input string tag, input logic [3:0] exp_fv,
                           input logic [2:0] exp_err, input logic exp_pass);
    start = 1'b1;
    tick();
    start = 1'b0;
    for (int c = 1; c <= 13; c++) begin
      if (c <= 12) check({tag, "_ab"}, 8'({or2_a, or2_b}), 8'((c - 1) / 3));
      check({tag, "_busy"}, 8'(or2_busy), 8'h1);
      check({tag, "_done"}, 8'(or2_done), 8'(c == 13));
      if (c < 13) tick();
    end
    check({tag, "_pass"}, 8'(or2_pass), 8'(exp_pass));
    check({tag, "_err"},  8'(or2_err),  8'(exp_err));
    check({tag, "_fv"},   8'(or2_fv),   8'(exp_fv));
    check({tag, "_nor_done"}, 8'(nor_done), 8'h1);
    check({tag, "_nor_fv"},   8'(nor_fv),   8'b1110);
    check({tag, "_nor_err"},  8'(nor_err),  8'd3);
    check({tag, "_nor_pass"}, 8'(nor_pass), 8'h0);
    tick();
    check({tag, "_post_busy"}, 8'(or2_busy), 8'h0);
    check({tag, "_post_done"}, 8'(or2_done), 8'h0);
    check({tag, "_post_ab"},   8'({or2_a, or2_b}), 8'h0);
    check({tag, "_held_fv"},   8'(or2_fv),   8'(exp_fv));
    check({tag, "_held_pass"}, 8'(or2_pass), 8'(exp_pass));
  endtask

  initial begin
    int done_cnt;
    rst_n = 1'b0;
    start = 1'b0;
    mode  = 2'd0;
    tick();
    tick();
    check_or2_idle_zero("reset");
    rst_n = 1'b1;
    tick();

    mode = 2'd0;
    sweep_or2("or_gate", 4'b0000, 3'd0, 1'b1);
    tick();
    mode = 2'd1;
    sweep_or2("and_gate", 4'b0110, 3'd2, 1'b0);
    tick();
    mode = 2'd2;
    sweep_or2("tied0", 4'b1110, 3'd3, 1'b0);
    tick();

    // start held high: SETTLE=1 sweeps end at cycle 9, next one starts at cycle 11
    mode = 2'd0;
    done_cnt = 0;
    start = 1'b1;
    tick();
    for (int c = 1; c <= 19; c++) begin
      if (or1_done) done_cnt++;
      check("hold_done", 8'(or1_done), 8'(c == 9 || c == 19));
      if (c == 10) check("hold_idle_gap", 8'(or1_busy), 8'h0);
      if (c == 11) check("hold_restart", 8'(or1_busy), 8'h1);
      if (c == 9 || c == 19) begin
        check("hold_pass", 8'(or1_pass), 8'h1);
        check("hold_err",  8'(or1_err),  8'h0);
        check("hold_fv",   8'(or1_fv),   8'h0);
      end
      if (c < 19) tick();
    end
    check("hold_done_count", 8'(done_cnt), 8'd2);
    start = 1'b0;
    for (int i = 0; i < 30; i++) tick();

    // Reset during vector 2 of a failing sweep
    mode = 2'd2;
    start = 1'b1;
    tick();
    start = 1'b0;
    for (int c = 1; c < 8; c++) tick();
    check("midrst_pre_ab",  8'({or2_a, or2_b}), 8'b10);
    check("midrst_pre_err", 8'(or2_err), 8'd1);
    rst_n = 1'b0;
    #1;
    check_or2_idle_zero("midrst");
    done_cnt = 0;
    for (int i = 0; i < 8; i++) begin
      tick();
      if (or2_done) done_cnt++;
    end
    check("midrst_no_done", 8'(done_cnt), 8'd0);
    rst_n = 1'b1;
    tick();
    mode = 2'd0;
    sweep_or2("after_rst", 4'b0000, 3'd0, 1'b1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
